bram_rsp: RTL
=============

# bram_rsp

Responder front-end for the single-port-pair `bram` block: accepts read/write requests from an initiator over a valid/ready handshake and drives the BRAM write and read ports. It returns read data in request order on a valid/ready response channel, buffering enough entries to sustain one request per cycle under backpressure. It sits between any BRAM user (bench exerciser, CPU, DMA) and the `bram` instance, replacing hand-sequenced `wr_en`/`rd_en` pulsing.

## Interface
- `ADDR_SZ`, 8, BRAM address width
- `DATA_SZ`, 16, BRAM data width
- `i_clk`  in  1  system clock; all state on rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_req_valid`  in  1  request present
- `o_req_ready`  out  1  request accepted when `i_req_valid & o_req_ready` at a rising edge
- `i_req_wr`  in  1  1 = write, 0 = read
- `i_req_addr`  in  ADDR_SZ  request address
- `i_req_data`  in  DATA_SZ  write data (ignored for reads)
- `o_rsp_valid`  out  1  read response present
- `i_rsp_ready`  in  1  response consumed when `o_rsp_valid & i_rsp_ready` at a rising edge
- `o_rsp_data`  out  DATA_SZ  read data
- `o_rsp_addr`  out  ADDR_SZ  address the response belongs to
- `o_wr_en`, `o_waddr`, `o_wdata`  out  1/ADDR_SZ/DATA_SZ  to `bram` `i_wr_en`/`i_waddr`/`i_wdata`
- `o_rd_en`, `o_raddr`  out  1/ADDR_SZ  to `bram` `i_rd_en`/`i_raddr`
- `i_rdata`  in  DATA_SZ  from `bram` `o_rdata`

## Operation
- State: `inflight` (1 bit, read issued last cycle), `inflight_addr`, 3-entry response FIFO (data+addr), `count` 0..3, 2-bit read/write pointers wrapping 2→0.
- `o_req_ready = i_rst_n & (count + inflight < 3)`; depends on state only, never on `i_req_valid`, `i_req_wr` or `i_rsp_ready`.
- `accept = i_req_valid & o_req_ready`.
- BRAM drive is combinational from the request: `o_wr_en = accept & i_req_wr`, `o_rd_en = accept & ~i_req_wr`, `o_waddr = o_raddr = i_req_addr`, `o_wdata = i_req_data`.
- Writes produce no response and complete at the accepting edge.
- Read accepted at edge E: `inflight` ← 1, `inflight_addr` ← `i_req_addr`. In the following cycle `i_rdata` is valid; at edge E+1 `{i_rdata, inflight_addr}` is pushed into the FIFO.
- `o_rsp_valid = (count != 0)`; `o_rsp_data`/`o_rsp_addr` = FIFO head; pop on `o_rsp_valid & i_rsp_ready`.
- Simultaneous push and pop: count unchanged, both pointers advance; pop with count=1 plus push yields head = pushed entry next cycle.
- Credit rule guarantees push never occurs with count=3; overflow is impossible by construction (assert in sim).
- Responses are strictly in request order; writes do not reorder reads.
- Read-after-write to same address in the next cycle returns the new data (BRAM write lands at accepting edge).
- Reset (async, any time): `inflight`=0, `count`=0, pointers=0; an in-flight read is discarded; BRAM contents untouched. While `i_rst_n`=0, `o_req_ready`=0 so `o_wr_en`=`o_rd_en`=0.

## Timing
- Reset values: `o_req_ready`=0 (1 the first cycle after release), `o_rsp_valid`=0, `o_wr_en`=0, `o_rd_en`=0; `o_rsp_data`/`o_rsp_addr` don't-care while `o_rsp_valid`=0.
- Read latency: accept at edge E → `o_rsp_valid` high in cycle after E+1 (2 cycles).
- Throughput: one request per cycle sustained while `i_rsp_ready`=1.
- With `i_rsp_ready` held 0: exactly 3 reads accepted, then `o_req_ready`=0 (writes also stall) until a pop.
- `o_rsp_*` stable while `o_rsp_valid & ~i_rsp_ready`.

## Test plan
- Reset then write addr 7 data 5, read addr 7 next cycle → `o_rsp_valid` 2 cycles after read accept, `o_rsp_data`=5, `o_rsp_addr`=7.
- Write addrs 0..15 with data addr*5, then 16 back-to-back reads, `i_rsp_ready`=1 → `o_req_ready` never drops, 16 responses in order, data 0,5,…,75.
- `i_rsp_ready`=0, continuous read requests → exactly 3 accepted, `o_req_ready`=0, `o_rsp_*` stable; release → remaining responses in order, no loss or duplicate.
- Random `i_rsp_ready` (50%) with mixed reads/writes over 1000 cycles vs. reference memory model → every response matches model, count never exceeds 3.
- Assert `i_rst_n`=0 one cycle after a read accept → no response appears after release, `o_req_ready`=1 next cycle, prior written data still readable.
- Write addr 255 data 16'hFFFF then read 255 and read 0 → addresses wrap-free, responses FFFF then addr-0 contents.

Source files
------------

// File: rtl/bram_rsp.sv
// rtl/bram_rsp.sv - valid/ready responder front-end for the bram block
module bram_rsp #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wr,
  input  logic [ADDR_SZ-1:0] i_req_addr,
  input  logic [DATA_SZ-1:0] i_req_data,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [DATA_SZ-1:0] o_rsp_data,
  output logic [ADDR_SZ-1:0] o_rsp_addr,
  output logic               o_wr_en,
  output logic [ADDR_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd_en,
  output logic [ADDR_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata
);

  logic [DATA_SZ-1:0] fifo_data [3];
  logic [ADDR_SZ-1:0] fifo_addr [3];
  logic [1:0]         count;
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic               inflight;
  logic [ADDR_SZ-1:0] inflight_addr;
  logic               accept;
  logic               push;
  logic               pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read in flight already owns a FIFO slot, so credit counts it too.
  assign o_req_ready = i_rst_n & (({1'b0, count} + {2'b00, inflight}) < 3'd3);
  assign accept      = i_req_valid & o_req_ready;

  assign o_wr_en = accept & i_req_wr;
  assign o_rd_en = accept & ~i_req_wr;
  assign o_waddr = i_req_addr;
  assign o_raddr = i_req_addr;
  assign o_wdata = i_req_data;

  assign push        = inflight;
  assign o_rsp_valid = (count != 2'd0);
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign o_rsp_data  = fifo_data[rd_ptr];
  assign o_rsp_addr  = fifo_addr[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
      count         <= 2'd0;
      wr_ptr        <= 2'd0;
      rd_ptr        <= 2'd0;
    end else begin
      inflight <= o_rd_en;
      if (o_rd_en) begin
        inflight_addr <= i_req_addr;
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= i_rdata;
      fifo_addr[wr_ptr] <= inflight_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) begin
      assert (count != 2'd3);
    end
  end

endmodule
